// File: rtl/spi_master_if.sv
// Bundle of the SPI master's data and serial-link signals.
//   datain   : parallel word to transmit (source -> master)
//   counter  : bits still to be sent in the current frame
//   spi_cs   : chip select, active low
//   spi_sclk : serial clock, idles low
//   spi_data : serial data (MOSI), MSB first
// The master modport is for the SPI master; the slave modport is for the
// side that supplies datain and observes the link.
interface spi_master_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] datain;
    logic [4:0]            counter;
    logic                  spi_cs;
    logic                  spi_sclk;
    logic                  spi_data;

    modport master (
        input  datain,
        output counter,
        output spi_cs,
        output spi_sclk,
        output spi_data
    );

    modport slave (
        output datain,
        input  counter,
        input  spi_cs,
        input  spi_sclk,
        input  spi_data
    );
endinterface

// File: rtl/spi_master.sv
// Free-running transmit-only SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// Every frame latches bus.datain in LOAD and shifts it out on spi_data while
// spi_cs is low; frames repeat back-to-back with a two-cycle spi_cs-high gap.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : spi_master_if master modport (datain in; counter, spi_cs,
//           spi_sclk, spi_data out, all registered)
// DATA_WIDTH must be 2..31 so the 5-bit counter can hold it; CLK_DIV >= 1.
module spi_master #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CLK_DIV    = 1
) (
    input  logic          clk,
    input  logic          reset,
    spi_master_if.master  bus
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      counter_q;
    logic [DIV_W-1:0]      div_q;
    logic                  cs_q;
    logic                  sclk_q;
    logic                  data_q;

    // Each state registers the outputs seen during the following cycle, so
    // the LOAD state's values appear one cycle after LOAD is entered and the
    // last falling edge (cs high) is followed by one IDLE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            counter_q <= '0;
            div_q     <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cs_q      <= 1'b1;
                    sclk_q    <= 1'b0;
                    data_q    <= 1'b0;
                    counter_q <= '0;
                    div_q     <= '0;
                    state     <= LOAD;
                end

                LOAD: begin
                    shift_q   <= bus.datain;
                    cs_q      <= 1'b0;
                    sclk_q    <= 1'b0;
                    data_q    <= bus.datain[DATA_WIDTH-1];
                    counter_q <= CNT_W'(DATA_WIDTH);
                    div_q     <= '0;
                    state     <= SHIFT;
                end

                SHIFT: begin
                    // Half-period timer; sclk toggles when it expires.
                    if (div_q == DIV_W'(CLK_DIV - 1)) begin
                        div_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            // Falling edge: last bit done ends the frame,
                            // otherwise present the next bit.
                            if (counter_q == CNT_W'(1)) begin
                                counter_q <= '0;
                                cs_q      <= 1'b1;
                                data_q    <= 1'b0;
                                state     <= IDLE;
                            end else begin
                                counter_q <= counter_q - CNT_W'(1);
                                shift_q   <= shift_q << 1;
                                data_q    <= shift_q[DATA_WIDTH-2];
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.counter  = counter_q;
    assign bus.spi_cs   = cs_q;
    assign bus.spi_sclk = sclk_q;
    assign bus.spi_data = data_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master (DATA_WIDTH=16, CLK_DIV=1, 100 MHz clk).
// A negedge monitor reassembles frames from the link and checks protocol
// rules; the stimulus checks words, timing and reset behaviour.
module tb_spi_master;

    localparam int unsigned DW = 16;

    logic clk;
    logic reset;

    spi_master_if #(.DATA_WIDTH(DW)) bus ();

    spi_master #(.DATA_WIDTH(DW), .CLK_DIV(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] word;
        int            nbits;
        int            low_len;
        int            gap;
        int            period;
        int            start;
    } frame_t;

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] exp_word;
        int            exp_period;
    } vec_t;

    frame_t q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;
    int     proto_err = 0;
    int     cnt_err = 0;

    // Monitor state
    logic   p_cs = 1'b1, p_sclk = 1'b0, p_data = 1'b0;
    logic   in_frame = 1'b0;
    int     falls = 0, hi_len = 0, last_start = 0;
    logic   have_start = 1'b0;
    frame_t cur;

    always @(negedge clk) begin
        logic cs, sclk, data;
        cyc++;
        cs   = bus.spi_cs;
        sclk = bus.spi_sclk;
        data = bus.spi_data;
        if (!reset) begin
            in_frame   = 1'b0;
            p_cs       = 1'b1;
            p_sclk     = 1'b0;
            p_data     = 1'b0;
            hi_len     = 0;
            have_start = 1'b0;
        end else begin
            if (cs && sclk) proto_err++;
            if (cs && p_cs && (sclk != p_sclk)) proto_err++;
            if ((data != p_data) && !(p_sclk && !sclk) && !(p_cs && !cs)) proto_err++;

            if (p_cs && !cs) begin
                in_frame     = 1'b1;
                cur.word     = '0;
                cur.nbits    = 0;
                cur.low_len  = 1;
                cur.gap      = hi_len;
                cur.start    = cyc;
                cur.period   = have_start ? (cyc - last_start) : 0;
                last_start   = cyc;
                have_start   = 1'b1;
                falls        = 0;
                if (int'(bus.counter) != 16) cnt_err++;
            end else if (!cs && in_frame) begin
                cur.low_len++;
                if (!p_sclk && sclk) begin
                    cur.word = {cur.word[DW-2:0], data};
                    cur.nbits++;
                end
                if (p_sclk && !sclk) falls++;
                if (int'(bus.counter) != 16 - falls) cnt_err++;
            end else if (cs && !p_cs && in_frame) begin
                if (p_sclk && !sclk) falls++;
                if (int'(bus.counter) != 0 || falls != 16) cnt_err++;
                q.push_back(cur);
                in_frame = 1'b0;
                hi_len   = 1;
            end else if (cs) begin
                hi_len++;
            end
            p_cs   = cs;
            p_sclk = sclk;
            p_data = data;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_frame(output frame_t f);
        int n;
        n = 0;
        while (q.size() == 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_timeout: got no frame expected one within 200 cycles");
            f = '{word: '0, nbits: 0, low_len: 0, gap: 0, period: 0, start: 0};
        end else begin
            f = q.pop_front();
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cs"},      int'(bus.spi_cs),   1);
        check({tag, "_sclk"},    int'(bus.spi_sclk), 0);
        check({tag, "_data"},    int'(bus.spi_data), 0);
        check({tag, "_counter"}, int'(bus.counter),  0);
    endtask

    initial begin
        vec_t   vecs[5];
        frame_t f;
        int     rel_cyc;
        int     n;

        vecs[0] = '{din: 16'h9B63, exp_word: 16'h9B63, exp_period: 34};
        vecs[1] = '{din: 16'h9B63, exp_word: 16'h9B63, exp_period: 34};
        vecs[2] = '{din: 16'h6A61, exp_word: 16'h6A61, exp_period: 34};
        vecs[3] = '{din: 16'hA265, exp_word: 16'hA265, exp_period: 34};
        vecs[4] = '{din: 16'h7564, exp_word: 16'h7564, exp_period: 34};

        // Reset held low with datain=0
        reset      = 1'b1;
        bus.datain = '0;
        #1 reset   = 1'b0;
        #2 check_idle("rst_a");
        #5 check_idle("rst_b");
        #4;
        rel_cyc    = cyc;
        reset      = 1'b1;
        bus.datain = 16'hA569;

        // First frame; datain changes mid-frame and must not tear it
        n = 0;
        while (bus.spi_cs && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(posedge clk);
        #1 bus.datain = 16'h2563;
        wait_frame(f);
        check("f1_word",  int'(f.word), 32'hA569);
        check("f1_nbits", f.nbits, 16);
        check("f1_cs_low", f.low_len, 32);
        check("f1_start_after_rel", f.start - rel_cyc, 2);

        wait_frame(f);
        check("f2_word",   int'(f.word), 32'h2563);
        check("f2_gap",    f.gap, 2);
        check("f2_period", f.period, 34);

        // Table: each word is set in the gap just before its frame's LOAD
        for (int i = 0; i < 5; i++) begin
            bus.datain = vecs[i].din;
            wait_frame(f);
            check($sformatf("vec%0d_word", i),   int'(f.word), int'(vecs[i].exp_word));
            check($sformatf("vec%0d_nbits", i),  f.nbits, 16);
            check($sformatf("vec%0d_period", i), f.period, vecs[i].exp_period);
            check($sformatf("vec%0d_gap", i),    f.gap, 2);
        end

        // Reset during bit 7 of a frame, then a fresh full frame
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.spi_cs == 1'b0 && int'(bus.counter) == 8) && n < 100);
        check("reach_bit7", int'(bus.counter), 8);
        #2 reset = 1'b0;
        #1 check_idle("midrst");
        q.delete();
        bus.datain = 16'hC3A5;
        @(negedge clk);
        @(negedge clk);
        #2;
        rel_cyc = cyc;
        reset   = 1'b1;
        wait_frame(f);
        check("restart_word",  int'(f.word), 32'hC3A5);
        check("restart_nbits", f.nbits, 16);
        check("restart_start", f.start - rel_cyc, 2);

        repeat (4) @(posedge clk);
        check("protocol_errors", proto_err, 0);
        check("counter_errors",  cnt_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100 us");
        $fatal(1);
    end

endmodule
